// File: rtl/adjacency_pkg.sv
// rtl/adjacency_pkg.sv - shared widths, table entry types and FSM states for the successor-list store
package adjacency_pkg;

  localparam int DEFAULT_MAX_NODES = 1024;
  localparam int DEFAULT_MAX_EDGES = 4096;
  localparam int NODE_WIDTH        = $clog2(DEFAULT_MAX_NODES);
  localparam int EDGE_PTR_WIDTH    = $clog2(DEFAULT_MAX_EDGES);

  typedef logic [NODE_WIDTH-1:0]   node_t;
  typedef logic [EDGE_PTR_WIDTH-1:0] edge_ptr_t;
  // Counts reach MAX_EDGES itself, hence one extra bit over a pointer.
  typedef logic [EDGE_PTR_WIDTH:0] edge_cnt_t;

  typedef struct packed {
    edge_ptr_t head;
    edge_cnt_t degree;
  } node_entry_t;

  typedef struct packed {
    node_t     dst;
    edge_ptr_t next;
    logic      has_next;
  } edge_entry_t;

  typedef enum logic [1:0] {
    BUILD,
    IDLE,
    FETCH,
    PRESENT
  } state_t;

endpackage

// File: rtl/adjacency_list_store_if.sv
// rtl/adjacency_list_store_if.sv - edge load, query and reply signals of the successor-list store
interface adjacency_list_store_if;
  import adjacency_pkg::*;

  logic      edge_valid;
  node_t     src_node;
  node_t     dst_node;
  logic      decoding_done;
  edge_cnt_t edge_count;
  logic      edge_overflow;

  logic      query_ready;
  logic      query_valid;
  node_t     query_data;

  logic      reply_ready;
  logic      reply_valid;
  logic      reply_last;
  logic      reply_empty;
  node_t     reply_data;
  edge_cnt_t reply_degree;

  modport master (
    output edge_valid, src_node, dst_node, decoding_done,
    output query_valid, query_data, reply_ready,
    input  edge_count, edge_overflow, query_ready,
    input  reply_valid, reply_last, reply_empty, reply_data, reply_degree
  );

  modport slave (
    input  edge_valid, src_node, dst_node, decoding_done,
    input  query_valid, query_data, reply_ready,
    output edge_count, edge_overflow, query_ready,
    output reply_valid, reply_last, reply_empty, reply_data, reply_degree
  );

endinterface

// File: rtl/adjacency_list_store_edge_table_ram.sv
// rtl/adjacency_list_store_edge_table_ram.sv - simple dual-port edge table with one-cycle synchronous read
module edge_table_ram
  import adjacency_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_EDGES
) (
  input  logic        clk,
  input  logic        we,
  input  edge_ptr_t   waddr,
  input  edge_entry_t wdata,
  input  logic        re,
  input  edge_ptr_t   raddr,
  output edge_entry_t rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  edge_entry_t mem [DEPTH];

  // Writes only happen while building and reads only while replying, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/adjacency_list_store.sv
// rtl/adjacency_list_store.sv - per-node linked successor lists with degree and LIFO reply streaming
module adjacency_list_store
  import adjacency_pkg::*;
#(
  parameter int MAX_NODES = DEFAULT_MAX_NODES,
  parameter int MAX_EDGES = DEFAULT_MAX_EDGES
) (
  input logic                  clk,
  input logic                  rst_n,
  adjacency_list_store_if.slave bus
);

  localparam int        NODE_AW    = $clog2(MAX_NODES);
  localparam edge_cnt_t EDGE_LIMIT = edge_cnt_t'(MAX_EDGES);

  state_t state;
  state_t state_next;

  // Node table: valid bits need reset, head/degree are plain LUT RAM rewritten on first insert.
  logic [MAX_NODES-1:0] node_valid;
  node_entry_t          node_mem [MAX_NODES];

  edge_cnt_t edge_count_r;
  logic      edge_overflow_r;
  edge_ptr_t next_ptr_r;
  logic      reply_last_r;
  logic      reply_empty_r;
  node_t     reply_data_r;
  edge_cnt_t reply_degree_r;
  logic      query_ready_c;
  logic      reply_valid_c;

  logic [NODE_AW-1:0] src_idx;
  logic [NODE_AW-1:0] query_idx;
  node_entry_t        src_entry;
  node_entry_t        query_entry;
  logic               src_known;
  logic               query_known;
  edge_cnt_t          src_degree_next;

  logic        edge_accept;
  logic        edge_reject;
  logic        query_fire;
  logic        reply_fire;
  logic        ram_re;
  edge_ptr_t   ram_waddr;
  edge_ptr_t   ram_raddr;
  edge_entry_t ram_wdata;
  edge_entry_t ram_rdata;

  assign src_idx     = bus.src_node[NODE_AW-1:0];
  assign query_idx   = bus.query_data[NODE_AW-1:0];
  assign src_entry   = node_mem[src_idx];
  assign query_entry = node_mem[query_idx];
  assign src_known   = node_valid[src_idx];
  assign query_known = node_valid[query_idx];

  assign edge_accept = (state == BUILD) && bus.edge_valid && (edge_count_r != EDGE_LIMIT);
  assign edge_reject = (state == BUILD) && bus.edge_valid && (edge_count_r == EDGE_LIMIT);
  assign query_fire  = (state == IDLE) && bus.query_valid;
  assign reply_fire  = (state == PRESENT) && bus.reply_ready;

  // New edge becomes the list head and points at the previous head (LIFO chain).
  assign ram_waddr       = edge_count_r[EDGE_PTR_WIDTH-1:0];
  assign ram_wdata       = '{dst: bus.dst_node, next: src_entry.head, has_next: src_known};
  assign src_degree_next = src_known ? (src_entry.degree + edge_cnt_t'(1)) : edge_cnt_t'(1);

  assign ram_re    = (query_fire && query_known) || (reply_fire && !reply_last_r);
  assign ram_raddr = (state == IDLE) ? query_entry.head : next_ptr_r;

  edge_table_ram #(
    .DEPTH (MAX_EDGES)
  ) u_edge_table (
    .clk   (clk),
    .we    (edge_accept),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Head/degree update for the source node of an accepted edge.
  always_ff @(posedge clk) begin
    if (edge_accept) begin
      node_mem[src_idx] <= '{head: ram_waddr, degree: src_degree_next};
    end
  end

  // Node valid bits: cleared by reset, set on the first edge of a source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      node_valid <= '0;
    end else if (edge_accept) begin
      node_valid[src_idx] <= 1'b1;
    end
  end

  // Edge counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_count_r    <= '0;
      edge_overflow_r <= 1'b0;
    end else begin
      if (edge_accept) begin
        edge_count_r <= edge_count_r + edge_cnt_t'(1);
      end
      if (edge_reject) begin
        edge_overflow_r <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BUILD;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and state-decoded handshake outputs.
  always_comb begin
    state_next    = state;
    query_ready_c = 1'b0;
    reply_valid_c = 1'b0;
    case (state)
      BUILD: begin
        if (bus.decoding_done) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        query_ready_c = 1'b1;
        if (bus.query_valid) begin
          state_next = query_known ? FETCH : PRESENT;
        end
      end
      FETCH: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        reply_valid_c = 1'b1;
        if (bus.reply_ready) begin
          state_next = reply_last_r ? IDLE : FETCH;
        end
      end
      default: begin
        state_next = BUILD;
      end
    endcase
  end

  // Reply registers: degree/empty latched on accept, beat fields loaded from the edge table in FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reply_last_r   <= 1'b0;
      reply_empty_r  <= 1'b0;
      reply_data_r   <= '0;
      reply_degree_r <= '0;
      next_ptr_r     <= '0;
    end else if (query_fire) begin
      reply_degree_r <= query_known ? query_entry.degree : '0;
      reply_empty_r  <= !query_known;
      reply_last_r   <= !query_known;
      reply_data_r   <= '0;
    end else if (state == FETCH) begin
      reply_data_r <= ram_rdata.dst;
      reply_last_r <= !ram_rdata.has_next;
      next_ptr_r   <= ram_rdata.next;
    end
  end

  assign bus.edge_count    = edge_count_r;
  assign bus.edge_overflow = edge_overflow_r;
  assign bus.query_ready   = query_ready_c;
  assign bus.reply_valid   = reply_valid_c;
  assign bus.reply_last    = reply_last_r;
  assign bus.reply_empty   = reply_empty_r;
  assign bus.reply_data    = reply_data_r;
  assign bus.reply_degree  = reply_degree_r;

endmodule

// File: tb/tb_adjacency_list_store.sv
// tb/tb_adjacency_list_store.sv - self-checking bench for the successor-list store
module tb_adjacency_list_store;
  import adjacency_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adjacency_list_store_if ifa ();
  adjacency_list_store_if ifb ();

  adjacency_list_store dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  adjacency_list_store #(
    .MAX_EDGES (4)
  ) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    node_t node;
    int    degree;
    node_t beat0;
    node_t beat1;
    node_t beat2;
  } qvec_t;

  int checks = 0;
  int failures = 0;

  node_t model_adj [DEFAULT_MAX_NODES][$];
  int    model_count;
  bit    model_building;

  node_t exp_q[$];
  node_t got_data_q[$];
  bit    got_empty_q[$];
  int    got_deg_q[$];
  int    got_lat;
  int    got_last_cyc;
  bit    got_done;

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEFAULT_MAX_NODES; i++) model_adj[i].delete();
    model_count = 0;
    model_building = 1'b1;
  endtask

  task automatic idle_inputs();
    ifa.edge_valid = 1'b0; ifa.src_node = '0; ifa.dst_node = '0; ifa.decoding_done = 1'b0;
    ifa.query_valid = 1'b0; ifa.query_data = '0; ifa.reply_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add_edge(input node_t s, input node_t d, input bit done);
    ifa.edge_valid = 1'b1; ifa.src_node = s; ifa.dst_node = d; ifa.decoding_done = done;
    step();
    ifa.edge_valid = 1'b0; ifa.decoding_done = 1'b0;
    if (model_building && model_count < DEFAULT_MAX_EDGES) begin
      model_adj[s].push_back(d);
      model_count++;
    end
    if (done) model_building = 1'b0;
  endtask

  task automatic load_expected(input node_t n);
    exp_q.delete();
    for (int i = model_adj[n].size() - 1; i >= 0; i--) exp_q.push_back(model_adj[n][i]);
  endtask

  // mode 0: always ready, 1: fixed 1,0,0,1 pattern, 2: random ready
  task automatic do_query(input node_t n, input int mode);
    int guard;
    int k;
    bit hold;
    node_t hold_data;
    logic hold_last;
    got_data_q.delete(); got_empty_q.delete(); got_deg_q.delete();
    got_lat = -1; got_last_cyc = -1; got_done = 1'b0;
    guard = 0;
    while (ifa.query_ready !== 1'b1 && guard < 20) begin step(); guard++; end
    check("query_ready_wait", ifa.query_ready, 1);
    ifa.query_valid = 1'b1; ifa.query_data = n; ifa.reply_ready = 1'b0;
    step();
    ifa.query_valid = 1'b0;
    hold = 1'b0; hold_data = '0; hold_last = 1'b0; k = 0;
    for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
      if (mode == 0) ifa.reply_ready = 1'b1;
      else if (mode == 1) ifa.reply_ready = pat[k % 4];
      else ifa.reply_ready = 1'($urandom_range(0, 1));
      k++;
      if (hold) begin
        check("stall_hold_valid", ifa.reply_valid, 1);
        check("stall_hold_data", ifa.reply_data, hold_data);
        check("stall_hold_last", ifa.reply_last, hold_last);
      end
      hold = 1'b0;
      if (ifa.reply_valid === 1'b1) begin
        if (got_lat < 0) got_lat = cyc;
        if (ifa.reply_ready) begin
          got_data_q.push_back(ifa.reply_data);
          got_empty_q.push_back(ifa.reply_empty);
          got_deg_q.push_back(int'(ifa.reply_degree));
          if (ifa.reply_last === 1'b1) begin
            got_done = 1'b1;
            got_last_cyc = cyc;
          end
        end else begin
          hold = 1'b1; hold_data = ifa.reply_data; hold_last = ifa.reply_last;
        end
      end
      if (!got_done) step();
    end
    check("reply_completed", got_done, 1);
  endtask

  task automatic check_reply(input string name, input int mode);
    bit exp_empty;
    int exp_beats;
    exp_empty = (exp_q.size() == 0);
    exp_beats = exp_empty ? 1 : exp_q.size();
    check({name, "_beats"}, got_data_q.size(), exp_beats);
    if (got_data_q.size() == exp_beats) begin
      for (int i = 0; i < exp_beats; i++) begin
        if (!exp_empty) check({name, "_data"}, got_data_q[i], exp_q[i]);
        check({name, "_empty"}, got_empty_q[i], exp_empty);
        check({name, "_degree"}, got_deg_q[i], exp_q.size());
      end
    end
    check({name, "_latency"}, got_lat, exp_empty ? 1 : 2);
    if (mode == 0) check({name, "_last_cycle"}, got_last_cyc, exp_empty ? 1 : 2 * exp_beats);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    qvec_t qtab[3];
    int guard;
    int mode;
    node_t n;
    node_t s_small [5];
    node_t d_small [5];
    node_t small_got[$];

    qtab[0] = '{node: 10'd3, degree: 3, beat0: 10'd1, beat1: 10'd9, beat2: 10'd7};
    qtab[1] = '{node: 10'd5, degree: 1, beat0: 10'd2, beat1: 10'd0, beat2: 10'd0};
    qtab[2] = '{node: 10'd8, degree: 0, beat0: 10'd0, beat1: 10'd0, beat2: 10'd0};

    ifb.edge_valid = 1'b0; ifb.src_node = '0; ifb.dst_node = '0; ifb.decoding_done = 1'b0;
    ifb.query_valid = 1'b0; ifb.query_data = '0; ifb.reply_ready = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst_query_ready", ifa.query_ready, 0);
    check("rst_reply_valid", ifa.reply_valid, 0);
    check("rst_reply_last", ifa.reply_last, 0);
    check("rst_reply_empty", ifa.reply_empty, 0);
    check("rst_reply_data", ifa.reply_data, 0);
    check("rst_reply_degree", ifa.reply_degree, 0);
    check("rst_edge_count", ifa.edge_count, 0);
    check("rst_edge_overflow", ifa.edge_overflow, 0);
    check("rst_small_edge_count", ifb.edge_count, 0);
    rst_n = 1'b1;
    model_reset();

    // directed build; last edge arrives together with decoding_done
    add_edge(10'd3, 10'd7, 1'b0);
    add_edge(10'd5, 10'd2, 1'b0);
    add_edge(10'd3, 10'd9, 1'b0);
    add_edge(10'd3, 10'd1, 1'b1);
    check("dir_edge_count", ifa.edge_count, 4);
    add_edge(10'd6, 10'd6, 1'b0);
    check("late_edge_ignored", ifa.edge_count, 4);
    check("done_deassert_idle", ifa.query_ready, 1);

    for (int i = 0; i < 3; i++) begin
      exp_q.delete();
      if (qtab[i].degree > 0) exp_q.push_back(qtab[i].beat0);
      if (qtab[i].degree > 1) exp_q.push_back(qtab[i].beat1);
      if (qtab[i].degree > 2) exp_q.push_back(qtab[i].beat2);
      do_query(qtab[i].node, 0);
      check_reply("table", 0);
    end

    exp_q.delete();
    exp_q.push_back(10'd1); exp_q.push_back(10'd9); exp_q.push_back(10'd7);
    do_query(10'd3, 1);
    check_reply("stalled", 1);
    do_query(10'd6, 0);
    exp_q.delete();
    check_reply("late_src_absent", 0);

    // reset while a multi-beat reply is being presented
    guard = 0;
    while (ifa.query_ready !== 1'b1 && guard < 20) begin step(); guard++; end
    ifa.query_valid = 1'b1; ifa.query_data = 10'd3; ifa.reply_ready = 1'b0;
    step();
    ifa.query_valid = 1'b0;
    guard = 0;
    while (ifa.reply_valid !== 1'b1 && guard < 10) begin step(); guard++; end
    check("midrst_reply_up", ifa.reply_valid, 1);
    rst_n = 1'b0;
    step();
    check("midrst_valid_low", ifa.reply_valid, 0);
    check("midrst_query_ready", ifa.query_ready, 0);
    check("midrst_edge_count", ifa.edge_count, 0);
    rst_n = 1'b1;
    ifa.reply_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_beat", ifa.reply_valid, 0);
    end
    model_reset();
    ifa.decoding_done = 1'b1;
    step();
    ifa.decoding_done = 1'b0;
    model_building = 1'b0;
    exp_q.delete();
    do_query(10'd3, 0);
    check_reply("requery_after_reset", 0);

    // randomized build and queries against the list model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) step();
      add_edge(node_t'($urandom_range(0, 15)), node_t'($urandom), i == 299);
    end
    check("rand_edge_count", ifa.edge_count, model_count);
    for (int i = 0; i < 40; i++) begin
      n = node_t'($urandom_range(0, 23));
      mode = int'($urandom_range(0, 2));
      load_expected(n);
      do_query(n, mode);
      check_reply("rand", mode);
    end
    check("rand_no_overflow", ifa.edge_overflow, 0);

    // overflow on the four-entry instance
    do_reset();
    s_small = '{10'd1, 10'd2, 10'd1, 10'd2, 10'd1};
    d_small = '{10'd10, 10'd11, 10'd12, 10'd13, 10'd14};
    for (int i = 0; i < 5; i++) begin
      ifb.edge_valid = 1'b1; ifb.src_node = s_small[i]; ifb.dst_node = d_small[i];
      step();
    end
    ifb.edge_valid = 1'b0;
    check("small_edge_count", ifb.edge_count, 4);
    check("small_overflow", ifb.edge_overflow, 1);
    ifb.decoding_done = 1'b1;
    step();
    ifb.decoding_done = 1'b0;
    check("small_overflow_sticky", ifb.edge_overflow, 1);
    check("small_query_ready", ifb.query_ready, 1);
    ifb.query_valid = 1'b1; ifb.query_data = 10'd1; ifb.reply_ready = 1'b1;
    step();
    ifb.query_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ifb.reply_valid === 1'b1) begin
        small_got.push_back(ifb.reply_data);
        check("small_degree", ifb.reply_degree, 2);
        if (ifb.reply_last === 1'b1) break;
      end
      step();
    end
    check("small_beats", small_got.size(), 2);
    if (small_got.size() == 2) begin
      check("small_beat0", small_got[0], 12);
      check("small_beat1", small_got[1], 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
